fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Dual-wide instruction queue between the I-cache fetch unit and the decode stage.
- Accepts fetch packets of up to 2 instructions per cycle and stores individual instructions in a circular buffer.
- Presents instructions to decode as in-order pairs (inst0/inst1, single inst_val) and absorbs decode/rename back-pressure.
- Fills a missing second slot with a zero word. Opcode 0 is an illegal opcode, so decode marks that slot invalid.

Parameters:
- DEPTH, 8, number of single-instruction entries; power of 2, at least 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; empties the buffer
- fetch_rdy  out  1  buffer can accept a full packet this cycle
- fetch_val  in  1  fetch packet valid
- fetch_pc  in  CPU_ADDR_BITS  PC of slot 0 (8-byte aligned)
- fetch_inst0  in  CPU_INST_BITS  instruction at fetch_pc
- fetch_inst1  in  CPU_INST_BITS  instruction at fetch_pc+4
- fetch_mask  in  2  per-slot valid; bit0 = slot0, bit1 = slot1
- decode_rdy  in  1  decode consumes the presented pair this cycle
- inst0_pc  out  CPU_ADDR_BITS  PC of oldest entry
- inst1_pc  out  CPU_ADDR_BITS  PC of second-oldest entry, else inst0_pc+4
- inst0  out  CPU_INST_BITS  oldest instruction
- inst1  out  CPU_INST_BITS  second-oldest instruction, or 0 if absent
- inst_val  out  1  at least one instruction presented
- fb_count  out  $clog2(DEPTH)+1  current occupancy (debug/perf)

Behaviour:
- Storage and pointers:
  - Storage is DEPTH entries of {pc, inst}, with head pointer, tail pointer and count registers.
  - Pointers wrap modulo DEPTH.
- Reset/flush:
  - On rst, or on flush in a cycle without rst: head=tail=count=0.
  - Enqueue and dequeue in that same cycle are ignored.
  - Resulting outputs: inst_val=0, inst0=inst1=0, inst0_pc=inst1_pc=0, fb_count=0, fetch_rdy=1.
  - Entry storage need not be cleared.
- fetch_rdy:
  - fetch_rdy = (DEPTH - count) >= 2, from registered count only.
  - It does not credit a same-cycle dequeue and is combinationally independent of decode_rdy.
- Enqueue fires when fetch_val && fetch_rdy && !flush:
  - mask 2'b11: write {fetch_pc, inst0} at tail and {fetch_pc+4, inst1} at tail+1; tail += 2.
  - mask 2'b01: write slot0 only; tail += 1.
  - mask 2'b10: write {fetch_pc+4, inst1} at tail; tail += 1 (branch target at odd word).
  - mask 2'b00: no write.
  - fetch_val while !fetch_rdy: packet dropped. Fetch must hold it; a packet presented without fetch_rdy is a protocol violation.
- Presentation (combinational from head and count; no enqueue-to-output bypass):
  - inst_val = count >= 1.
  - inst0/inst0_pc = entry[head].
  - If count >= 2: inst1/inst1_pc = entry[head+1].
  - Else: inst1 = 0 and inst1_pc = inst0_pc + 4.
  - When count == 0, all data outputs are 0.
- Dequeue fires when inst_val && decode_rdy && !flush:
  - head += min(count, 2); count reduces by the same amount.
- Latency: an instruction enqueued in cycle N is first presented in cycle N+1.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Both pointers update the same cycle.
- Full: count == DEPTH-1 or DEPTH gives fetch_rdy=0. Dequeue still works.
- Ordering:
  - Strict program order; slot0 precedes slot1 within a packet.
  - inst1_pc is never derived from inst0_pc when a real second entry exists; the two may be non-contiguous across taken branches.
- Overflow is impossible under protocol. An assertion checks count <= DEPTH.

Decomposition:
- uarch_pkg additions:
  - FB_DEPTH constant (default 8).
  - fb_entry_t typedef {logic [CPU_ADDR_BITS-1:0] pc; logic [CPU_INST_BITS-1:0] inst;}.
  - INST_BUBBLE = 32'h0 constant.
- Existing constants reused: CPU_ADDR_BITS, CPU_INST_BITS.
- No sub-module: the single circular buffer with 2-write/2-read ports stays inline.

Test Plan:
1. Reset, then packet pc=0x100, {0x00500093, 0x00600113}, mask 2'b11, decode_rdy=1 -> next cycle inst_val=1, inst0_pc=0x100, inst1_pc=0x104, both instructions presented; following cycle inst_val=0, fb_count=0.
2. Single packet pc=0x200, mask 2'b10, inst1=0x00700193 -> inst0=0x00700193, inst0_pc=0x204, inst1=0, inst1_pc=0x208, inst_val=1.
3. decode_rdy=0, push 2'b11 packets every cycle with DEPTH=8 -> fb_count reaches 8 after 4 accepted packets, fetch_rdy=0 from count 7 onward; raise decode_rdy -> 2 dequeued per cycle, fetch_rdy returns to 1, order preserved across pointer wrap.
4. count=3, decode_rdy=1, and a 2'b11 packet the same cycle -> count_next=3; presented pairs are oldest-first with no gap.
5. count=5, assert flush together with fetch_val and a 2'b11 mask -> next cycle count=0, inst_val=0, fetch_rdy=1, none of the flushed packet's instructions appear.
6. rst asserted mid-stream with count=6 -> next cycle all outputs at reset values; a new packet is accepted immediately and appears at inst0 one cycle later.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the front end.
package uarch_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_INST_BITS = 32;

    // Fetch buffer sizing: single-instruction entries, power of 2, at least 4.
    localparam int FB_DEPTH = 8;

    // Opcode 0 is illegal, so decode treats an all-zero word as an empty slot.
    localparam logic [CPU_INST_BITS-1:0] INST_BUBBLE = 32'h0;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_INST_BITS-1:0] inst;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Dual-wide instruction queue between fetch and decode. Fetch packets of up
// to two instructions are split into single entries of a circular buffer and
// presented to decode as in-order pairs.
module fetch_buffer
    import uarch_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    output logic                      fetch_rdy,
    input  logic                      fetch_val,
    input  logic [CPU_ADDR_BITS-1:0]  fetch_pc,
    input  logic [CPU_INST_BITS-1:0]  fetch_inst0,
    input  logic [CPU_INST_BITS-1:0]  fetch_inst1,
    input  logic [1:0]                fetch_mask,
    input  logic                      decode_rdy,
    output logic [CPU_ADDR_BITS-1:0]  inst0_pc,
    output logic [CPU_ADDR_BITS-1:0]  inst1_pc,
    output logic [CPU_INST_BITS-1:0]  inst0,
    output logic [CPU_INST_BITS-1:0]  inst1,
    output logic                      inst_val,
    output logic [$clog2(DEPTH):0]    fb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W-1:0]   head_p1, tail_p1;
    logic [CNT_W-1:0]   count, count_next;

    logic               enq_fire, deq_fire;
    logic [1:0]         n_enq, n_deq;
    logic               wr0_en, wr1_en;
    fb_entry_t          wr0_data, wr1_data;

    // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH for free.
    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Readiness looks only at registered occupancy, never at this cycle's
    // dequeue, so fetch never sees a combinational path from decode_rdy.
    assign fetch_rdy = (count <= CNT_W'(DEPTH - 2));
    assign inst_val  = (count != '0);
    assign enq_fire  = fetch_val && fetch_rdy && !flush;
    assign deq_fire  = inst_val && decode_rdy && !flush;
    assign fb_count  = count;

    // Steer the packet's valid slots onto the two write ports, oldest first.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value held and no latch is inferred.
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = '0;
        wr1_data = '0;
        n_enq    = 2'd0;
        if (enq_fire) begin
            case (fetch_mask)
                2'b11: begin
                    wr0_en   = 1'b1;
                    wr0_data = '{pc: fetch_pc, inst: fetch_inst0};
                    wr1_en   = 1'b1;
                    wr1_data = '{pc: fetch_pc + CPU_ADDR_BITS'(4), inst: fetch_inst1};
                    n_enq    = 2'd2;
                end
                2'b01: begin
                    wr0_en   = 1'b1;
                    wr0_data = '{pc: fetch_pc, inst: fetch_inst0};
                    n_enq    = 2'd1;
                end
                2'b10: begin
                    // Branch target landed on the odd word of the packet.
                    wr0_en   = 1'b1;
                    wr0_data = '{pc: fetch_pc + CPU_ADDR_BITS'(4), inst: fetch_inst1};
                    n_enq    = 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Decode takes the whole presented pair: two entries, or one if only one exists.
    always_comb begin
        n_deq = 2'd0;
        if (deq_fire) begin
            n_deq = (count >= CNT_W'(2)) ? 2'd2 : 2'd1;
        end
        count_next = count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end

    // Present the two oldest entries; a missing second slot becomes a bubble.
    always_comb begin
        inst0    = '0;
        inst0_pc = '0;
        inst1    = '0;
        inst1_pc = '0;
        if (count != '0) begin
            inst0    = entries[head].inst;
            inst0_pc = entries[head].pc;
            if (count >= CNT_W'(2)) begin
                inst1    = entries[head_p1].inst;
                inst1_pc = entries[head_p1].pc;
            end else begin
                inst1    = INST_BUBBLE;
                inst1_pc = entries[head].pc + CPU_ADDR_BITS'(4);
            end
        end
    end

    // Pointer and occupancy registers; flush behaves like reset for these.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count_next;
        end
    end

    // Entry storage writes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are never
        // presented because count gates every read.
        if (wr0_en) entries[tail]    <= wr0_data;
        if (wr1_en) entries[tail_p1] <= wr1_data;
    end

    // Occupancy can never exceed capacity while fetch honours fetch_rdy.
    count_in_range: assert property (@(posedge clk) disable iff (rst)
                                     count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: table-driven vectors, directed
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_fetch_buffer;
    import uarch_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush, fetch_val, decode_rdy;
    logic [1:0]  fetch_mask;
    logic [31:0] fetch_pc, fetch_inst0, fetch_inst1;
    logic        fetch_rdy, inst_val;
    logic [31:0] inst0_pc, inst1_pc, inst0, inst1;
    logic [3:0]  fb_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ment_t;
    ment_t mq[$];

    typedef struct {
        logic        fv;
        logic [1:0]  mask;
        logic [31:0] pc, i0, i1;
        logic        drdy;
        logic        e_val;
        logic [31:0] e_i0, e_pc0, e_i1, e_pc1;
        logic [3:0]  e_cnt;
        logic        e_rdy;
    } vec_t;
    vec_t vecs[7];

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .fetch_rdy(fetch_rdy),
        .fetch_val(fetch_val), .fetch_pc(fetch_pc), .fetch_inst0(fetch_inst0),
        .fetch_inst1(fetch_inst1), .fetch_mask(fetch_mask), .decode_rdy(decode_rdy),
        .inst0_pc(inst0_pc), .inst1_pc(inst1_pc), .inst0(inst0), .inst1(inst1),
        .inst_val(inst_val), .fb_count(fb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [1:0] mask, input logic [31:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic drdy);
        fetch_val   = fv;
        fetch_mask  = mask;
        fetch_pc    = pc;
        fetch_inst0 = i0;
        fetch_inst1 = i1;
        decode_rdy  = drdy;
    endtask

    // Advance one clock; the model follows the buffer's rules on the same edge.
    task automatic tick();
        int sz;
        bit rdy;
        @(posedge clk);
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && decode_rdy) begin
                void'(mq.pop_front());
                if (sz > 1) void'(mq.pop_front());
            end
            if (fetch_val && rdy) begin
                case (fetch_mask)
                    2'b11: begin
                        mq.push_back('{pc: fetch_pc, inst: fetch_inst0});
                        mq.push_back('{pc: fetch_pc + 32'd4, inst: fetch_inst1});
                    end
                    2'b01: mq.push_back('{pc: fetch_pc, inst: fetch_inst0});
                    2'b10: mq.push_back('{pc: fetch_pc + 32'd4, inst: fetch_inst1});
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int sz;
        logic [31:0] e_i0, e_pc0, e_i1, e_pc1;
        sz    = mq.size();
        e_i0  = (sz > 0) ? mq[0].inst : 32'h0;
        e_pc0 = (sz > 0) ? mq[0].pc   : 32'h0;
        e_i1  = (sz > 1) ? mq[1].inst : 32'h0;
        e_pc1 = (sz > 1) ? mq[1].pc : ((sz > 0) ? mq[0].pc + 32'd4 : 32'h0);
        check({tag, ".val"},   64'(inst_val),  64'(sz > 0));
        check({tag, ".cnt"},   64'(fb_count),  64'(sz));
        check({tag, ".rdy"},   64'(fetch_rdy), 64'((DEPTH - sz) >= 2));
        check({tag, ".inst0"}, 64'(inst0),     64'(e_i0));
        check({tag, ".pc0"},   64'(inst0_pc),  64'(e_pc0));
        check({tag, ".inst1"}, 64'(inst1),     64'(e_i1));
        check({tag, ".pc1"},   64'(inst1_pc),  64'(e_pc1));
    endtask

    initial begin
        // Vector table: one cycle of stimulus each, expected outputs the cycle after.
        vecs[0] = '{1'b1, 2'b11, 32'h100, 32'h00500093, 32'h00600113, 1'b1,
                    1'b1, 32'h00500093, 32'h100, 32'h00600113, 32'h104, 4'd2, 1'b1};
        vecs[1] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1};
        vecs[2] = '{1'b1, 2'b10, 32'h200, 32'hDEADBEEF, 32'h00700193, 1'b0,
                    1'b1, 32'h00700193, 32'h204, 32'h0, 32'h208, 4'd1, 1'b1};
        vecs[3] = '{1'b1, 2'b01, 32'h300, 32'h11, 32'h22, 1'b0,
                    1'b1, 32'h00700193, 32'h204, 32'h11, 32'h300, 4'd2, 1'b1};
        vecs[4] = '{1'b1, 2'b00, 32'h400, 32'h33, 32'h44, 1'b1,
                    1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1};
        vecs[5] = '{1'b1, 2'b01, 32'h500, 32'h55, 32'h66, 1'b1,
                    1'b1, 32'h55, 32'h500, 32'h0, 32'h504, 4'd1, 1'b1};
        vecs[6] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1,
                    1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b1};

        do_reset();
        check("reset.val",   64'(inst_val),  64'(0));
        check("reset.cnt",   64'(fb_count),  64'(0));
        check("reset.rdy",   64'(fetch_rdy), 64'(1));
        check("reset.inst0", 64'(inst0),     64'(0));
        check("reset.pc1",   64'(inst1_pc),  64'(0));

        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].fv, vecs[v].mask, vecs[v].pc, vecs[v].i0, vecs[v].i1, vecs[v].drdy);
            tick();
            check($sformatf("vec%0d.val", v),   64'(inst_val),  64'(vecs[v].e_val));
            check($sformatf("vec%0d.inst0", v), 64'(inst0),     64'(vecs[v].e_i0));
            check($sformatf("vec%0d.pc0", v),   64'(inst0_pc),  64'(vecs[v].e_pc0));
            check($sformatf("vec%0d.inst1", v), 64'(inst1),     64'(vecs[v].e_i1));
            check($sformatf("vec%0d.pc1", v),   64'(inst1_pc),  64'(vecs[v].e_pc1));
            check($sformatf("vec%0d.cnt", v),   64'(fb_count),  64'(vecs[v].e_cnt));
            check($sformatf("vec%0d.rdy", v),   64'(fetch_rdy), 64'(vecs[v].e_rdy));
        end

        // Fill to full across a pointer wrap, then drain two per cycle.
        do_reset();
        drive(1'b1, 2'b01, 32'h0F8, 32'h99, 32'h0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill%0d.rdy", k), 64'(fetch_rdy), 64'(1));
            drive(1'b1, 2'b11, 32'h1000 + 32'(8 * k), 32'hA000 + 32'(2 * k),
                  32'hA001 + 32'(2 * k), 1'b0);
            tick();
        end
        check("full.cnt", 64'(fb_count),  64'(8));
        check("full.rdy", 64'(fetch_rdy), 64'(0));
        drive(1'b1, 2'b11, 32'h2000, 32'hBAD0, 32'hBAD1, 1'b0);
        tick();
        check("full.drop_cnt", 64'(fb_count), 64'(8));
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d.inst0", j), 64'(inst0),    64'(32'hA000 + 32'(2 * j)));
            check($sformatf("drain%0d.pc0", j),   64'(inst0_pc), 64'(32'h1000 + 32'(8 * j)));
            check($sformatf("drain%0d.inst1", j), 64'(inst1),    64'(32'hA001 + 32'(2 * j)));
            check($sformatf("drain%0d.pc1", j),   64'(inst1_pc), 64'(32'h1004 + 32'(8 * j)));
            tick();
            check($sformatf("drain%0d.cnt", j),   64'(fb_count), 64'(8 - 2 * (j + 1)));
            if (j == 0) check("drain0.rdy", 64'(fetch_rdy), 64'(1));
        end

        // Simultaneous enqueue and dequeue at count 3, then fill to 7.
        do_reset();
        drive(1'b1, 2'b11, 32'h3000, 32'hB0, 32'hB1, 1'b0);
        tick();
        drive(1'b1, 2'b01, 32'h3008, 32'hB2, 32'h0, 1'b0);
        tick();
        check("both.cnt_pre", 64'(fb_count), 64'(3));
        drive(1'b1, 2'b11, 32'h4000, 32'hB3, 32'hB4, 1'b1);
        check("both.inst0_pre", 64'(inst0), 64'(32'hB0));
        check("both.inst1_pre", 64'(inst1), 64'(32'hB1));
        tick();
        check("both.cnt",   64'(fb_count), 64'(3));
        check("both.inst0", 64'(inst0),    64'(32'hB2));
        check("both.pc0",   64'(inst0_pc), 64'(32'h3008));
        check("both.inst1", 64'(inst1),    64'(32'hB3));
        check("both.pc1",   64'(inst1_pc), 64'(32'h4000));
        drive(1'b1, 2'b11, 32'h5000, 32'hB5, 32'hB6, 1'b0);
        tick();
        drive(1'b1, 2'b11, 32'h5008, 32'hB7, 32'hB8, 1'b0);
        tick();
        check("seven.cnt", 64'(fb_count),  64'(7));
        check("seven.rdy", 64'(fetch_rdy), 64'(0));
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        check("seven.deq_cnt", 64'(fb_count), 64'(5));
        check("seven.inst0",   64'(inst0),    64'(32'hB4));
        check("seven.inst1",   64'(inst1),    64'(32'hB5));

        // Flush at count 5 with a packet offered in the same cycle.
        do_reset();
        drive(1'b1, 2'b11, 32'h6100, 32'hC5, 32'hC6, 1'b0);
        tick();
        drive(1'b1, 2'b11, 32'h6108, 32'hC7, 32'hC8, 1'b0);
        tick();
        drive(1'b1, 2'b01, 32'h6110, 32'hC9, 32'h0, 1'b0);
        tick();
        check("flush.cnt_pre", 64'(fb_count), 64'(5));
        flush = 1'b1;
        drive(1'b1, 2'b11, 32'h6000, 32'hC0, 32'hC1, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        check("flush.cnt",   64'(fb_count),  64'(0));
        check("flush.val",   64'(inst_val),  64'(0));
        check("flush.rdy",   64'(fetch_rdy), 64'(1));
        check("flush.inst0", 64'(inst0),     64'(0));
        tick();
        check("flush.stay_empty", 64'(fb_count), 64'(0));
        drive(1'b1, 2'b01, 32'h7000, 32'hC2, 32'h0, 1'b0);
        tick();
        check("flush.new_inst0", 64'(inst0), 64'(32'hC2));

        // Reset mid-stream at count 6, then immediate reuse.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b11, 32'h8100 + 32'(8 * k), 32'hE0 + 32'(k), 32'hF0 + 32'(k), 1'b0);
            tick();
        end
        check("rst.cnt_pre", 64'(fb_count), 64'(6));
        rst = 1'b1;
        drive(1'b1, 2'b11, 32'h8000, 32'hD0, 32'hD1, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b1, 2'b01, 32'h9000, 32'hD2, 32'h0, 1'b0);
        check("rst.val",   64'(inst_val),  64'(0));
        check("rst.cnt",   64'(fb_count),  64'(0));
        check("rst.rdy",   64'(fetch_rdy), 64'(1));
        check("rst.inst1", 64'(inst1),     64'(0));
        check("rst.pc0",   64'(inst0_pc),  64'(0));
        tick();
        check("rst.new_val",   64'(inst_val), 64'(1));
        check("rst.new_inst0", 64'(inst0),    64'(32'hD2));
        check("rst.new_pc0",   64'(inst0_pc), 64'(32'h9000));
        check("rst.new_cnt",   64'(fb_count), 64'(1));

        // Randomized traffic against the queue model; fetch honours readiness.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            drive(((DEPTH - mq.size()) >= 2) && ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFF8,
                  $urandom(), $urandom(), ($urandom_range(0, 2) != 0));
            check_model($sformatf("rand%0d", c));
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        check_model("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
